// File: rtl/countdown_timer.sv
// Programmable countdown timer: loads a period, decrements on prescaled ticks,
// and raises a sticky interrupt (with overrun detection) on expiry.
module countdown_timer #(
   parameter int Width    = 16,
   parameter int PreWidth = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic                periodic,
   input  logic [Width-1:0]    period,
   input  logic [PreWidth-1:0] prescale,
   input  logic                irq_ack,
   output logic                running,
   output logic [Width-1:0]    count,
   output logic                irq,
   output logic                overrun
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [Width-1:0]    count_q, count_d;
   logic [PreWidth-1:0] pre_q, pre_d;
   logic [Width-1:0]    periodLat_q, periodLat_d;
   logic [PreWidth-1:0] preLat_q, preLat_d;
   logic                modeLat_q, modeLat_d;
   logic                irq_q, irq_d;
   logic                ovr_q, ovr_d;
   logic                expiry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pre_q       <= '0;
         periodLat_q <= '0;
         preLat_q    <= '0;
         modeLat_q   <= 1'b0;
         irq_q       <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         pre_q       <= pre_d;
         periodLat_q <= periodLat_d;
         preLat_q    <= preLat_d;
         modeLat_q   <= modeLat_d;
         irq_q       <= irq_d;
         ovr_q       <= ovr_d;
      end
   end

   // Counting path: start beats stop, stop beats the prescaled tick.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      pre_d       = pre_q;
      periodLat_d = periodLat_q;
      preLat_d    = preLat_q;
      modeLat_d   = modeLat_q;
      expiry      = 1'b0;

      if (start) begin
         periodLat_d = period;
         preLat_d    = prescale;
         modeLat_d   = periodic;
         count_d     = period;
         pre_d       = prescale;
         state_d     = RUN;
      end else if (stop) begin
         state_d = IDLE;
      end else if (state_q == RUN) begin
         if (pre_q == '0) begin
            pre_d = preLat_q;
            if (count_q != '0) begin
               count_d = count_q - Width'(1);
            end else begin
               expiry = 1'b1;
               if (modeLat_q) begin
                  count_d = periodLat_q;
               end else begin
                  state_d = IDLE;
               end
            end
         end else begin
            pre_d = pre_q - PreWidth'(1);
         end
      end
   end

   // Interrupt flags: a new expiry wins over a simultaneous ack for irq,
   // but the ack still clears overrun.
   always_comb begin
      irq_d = irq_q;
      ovr_d = ovr_q;
      if (expiry) begin
         irq_d = 1'b1;
         if (irq_ack) begin
            ovr_d = 1'b0;
         end else if (irq_q) begin
            ovr_d = 1'b1;
         end
      end else if (irq_ack) begin
         irq_d = 1'b0;
         ovr_d = 1'b0;
      end
   end

   assign running = (state_q == RUN);
   assign count   = count_q;
   assign irq     = irq_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: an elapsed-time reference model predicts
// each cycle's outputs, and a monitor compares them one edge later.
module tb_countdown_timer;

   localparam int W  = 16;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, stop, periodic, irq_ack;
   logic [W-1:0]  period;
   logic [PW-1:0] prescale;
   logic          running, irq, overrun;
   logic [W-1:0]  count;

   int checks = 0;
   int errors = 0;
   int cycleNo = 0;

   logic [W+2:0] expQ[$];

   // Reference model state: latched setup plus edges elapsed since start.
   bit      mRun, mIrq, mOvr, mMode;
   int      mCount, mP, mS, mN;

   countdown_timer #(.Width(W), .PreWidth(PW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
      .period(period), .prescale(prescale), .irq_ack(irq_ack),
      .running(running), .count(count), .irq(irq), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycleNo, got, exp);
      end
   endtask

   task automatic modelReset();
      mRun = 0; mIrq = 0; mOvr = 0; mMode = 0;
      mCount = 0; mP = 0; mS = 0; mN = 0;
   endtask

   // Count is derived from ticks elapsed since start: every (S+1) edges is a
   // tick, and every (P+1) ticks is an expiry.
   task automatic modelStep(input bit st, input bit sp, input bit pm,
                            input int pd, input int ps, input bit ack);
      bit exp = 0;
      int k;
      if (st) begin
         mP = pd; mS = ps; mMode = pm; mN = 0;
         mRun = 1; mCount = pd;
      end else if (sp) begin
         mRun = 0;
      end else if (mRun) begin
         mN++;
         if (mN % (mS + 1) == 0) begin
            k = mN / (mS + 1);
            mCount = mP - (k % (mP + 1));
            if (k % (mP + 1) == 0) begin
               exp = 1;
               if (!mMode) begin
                  mRun = 0;
                  mCount = 0;
               end
            end
         end
      end
      if (exp) begin
         if (mIrq && !ack) mOvr = 1;
         if (ack) mOvr = 0;
         mIrq = 1;
      end else if (ack) begin
         mIrq = 0;
         mOvr = 0;
      end
   endtask

   task automatic applyStimulus(input bit st, input bit sp, input bit pm,
                                input int pd, input int ps, input bit ack);
      @(negedge clk);
      start = st; stop = sp; periodic = pm; irq_ack = ack;
      period = W'(pd); prescale = PW'(ps);
      modelStep(st, sp, pm, pd, ps, ack);
      expQ.push_back({mRun, W'(mCount), mIrq, mOvr});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(0, 0, $urandom_range(0, 1), $urandom_range(0, 100), $urandom_range(0, 9), 0);
   endtask

   task automatic drain();
      int guard = 0;
      @(negedge clk);
      start = 0; stop = 0; irq_ack = 0;
      while (expQ.size() > 0 && guard < 50) begin
         @(posedge clk);
         #2;
         guard++;
      end
      checkOutput("drain", expQ.size(), 0);
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge.
   initial begin
      logic [W+2:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cycleNo++;
            checkOutput("running", running, e[W+2]);
            checkOutput("count", count, e[W+1:2]);
            checkOutput("irq", irq, e[1]);
            checkOutput("overrun", overrun, e[0]);
         end
      end
   end

   initial begin
      rst = 1; start = 0; stop = 0; periodic = 0; irq_ack = 0;
      period = '0; prescale = '0;
      modelReset();
      #1;
      checkOutput("reset_running", running, 0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_irq", irq, 0);
      checkOutput("reset_overrun", overrun, 0);
      @(negedge clk);
      rst = 0;

      // One-shot, period 3, prescale 1: expiry 8 edges after start.
      applyStimulus(1, 0, 0, 3, 1, 0);
      idle(11);
      applyStimulus(0, 0, 0, 0, 0, 1);
      idle(2);

      // Periodic without ack builds overrun, then ack clears.
      applyStimulus(1, 0, 1, 2, 0, 0);
      idle(7);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 0);
      idle(2);

      // Ack landing on an expiry edge.
      applyStimulus(1, 0, 1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 0, 0, 1);
      idle(1);

      // Stop at count 5, hold, then restart with period 1.
      applyStimulus(1, 0, 0, 9, 0, 0);
      idle(4);
      applyStimulus(0, 1, 0, 0, 0, 0);
      idle(10);
      applyStimulus(1, 0, 0, 1, 0, 0);
      idle(3);
      applyStimulus(0, 0, 0, 0, 0, 1);

      // Start and stop together act as start.
      applyStimulus(1, 1, 0, 6, 2, 0);
      idle(4);

      // Build irq and overrun, then reset asynchronously mid-count.
      applyStimulus(1, 0, 1, 0, 0, 0);
      idle(3);
      drain();
      checkOutput("pre_rst_overrun", overrun, 1);
      #3;
      rst = 1;
      #1;
      checkOutput("async_rst_running", running, 0);
      checkOutput("async_rst_count", count, 0);
      checkOutput("async_rst_irq", irq, 0);
      checkOutput("async_rst_overrun", overrun, 0);
      modelReset();
      @(negedge clk);
      rst = 0;
      idle(6);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit st = ($urandom_range(0, 11) == 0);
         bit sp = ($urandom_range(0, 19) == 0);
         bit ak = ($urandom_range(0, 5) == 0);
         int pd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 6);
         applyStimulus(st, sp, $urandom_range(0, 1), pd, $urandom_range(0, 3), ak);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Programmable countdown timer. It loads a period, decrements it on prescaled ticks, and raises a sticky interrupt on expiry.
- It is the consumer/event side of the counter family: the up/down counter produces counts, and this block turns an elapsed count into an event for the CPU interrupt logic.
- Supports one-shot and periodic modes, a sticky irq with an ack handshake, and overrun detection.

Parameters:
- Width, 16, width of the period and the remaining count.
- PreWidth, 8, width of the prescaler divisor.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; (re)arms the timer with period/prescale/periodic.
- stop  input  1  one-cycle pulse; halts counting and holds count.
- periodic  input  1  mode select, sampled only on start: 1 = auto-reload, 0 = one-shot.
- period  input  Width  reload value, sampled only on start.
- prescale  input  PreWidth  divisor, sampled only on start; one tick every prescale+1 cycles.
- irq_ack  input  1  clears irq and overrun.
- running  output  1  timer armed and counting.
- count  output  Width  remaining count (registered).
- irq  output  1  sticky expiry interrupt.
- overrun  output  1  sticky; expiry occurred while irq was still pending.

Behaviour:
- Reset (asynchronous, any time, including mid-count):
  - running=0, count=0, irq=0, overrun=0.
  - Internal prescaler=0, latched period=0, latched prescale=0, latched mode=0.
- State: IDLE (running=0) and RUN (running=1).
- Priority per edge: start > stop > tick. irq_ack is handled independently of start/stop/tick.
- On start (any state):
  - Latch period, prescale and periodic.
  - count<=period, prescaler<=prescale, running<=1.
  - irq/overrun are unchanged, except that irq_ack in the same cycle clears them.
- On stop (without start):
  - running<=0.
  - count and prescaler hold; irq is unaffected.
  - A later start reloads fully; there is no resume.
- Prescaler (in RUN only):
  - If prescaler==0, tick=1 and prescaler<=latched prescale.
  - Otherwise prescaler decrements.
  - prescale=0 gives a tick every cycle.
- On tick:
  - count!=0: count<=count-1.
  - count==0: expiry.
    - periodic=1: count<=latched period, running stays 1.
    - periodic=0: running<=0, count stays 0.
- Timing:
  - The first expiry edge is (period+1)*(prescale+1) clock edges after the start edge.
  - irq is visible from that edge.
  - Periodic expiries follow every (period+1)*(prescale+1) cycles.
  - period=0 expires on every tick.
- irq/overrun on expiry:
  - irq<=1.
  - If irq was already 1 and irq_ack is not asserted that cycle, overrun<=1.
- irq_ack:
  - Without expiry: irq<=0, overrun<=0.
  - Simultaneous with expiry: irq stays 1 (set wins), overrun<=0.
- Counting arithmetic is unsigned with no wrap: count never decrements below 0, because expiry reloads or stops.
- In IDLE: no ticks, count holds, and irq holds until acked.

Test Plan:
- Reset, then start with period=3, prescale=1, periodic=0 → irq rises exactly 8 edges after start; count sequence 3,3,2,2,1,1,0,0; running drops at the irq edge; irq stays high until irq_ack, then clears next edge.
- start with period=2, prescale=0, periodic=1, and no ack:
  - irq at edge 3; overrun=1 at edge 6; count sequence 2,1,0,2,1,0,2.
  - irq_ack then clears both flags.
- Periodic timer with irq_ack pulsed on the same edge as an expiry → irq stays 1, overrun stays 0.
- stop at count=5 (period=9, prescale=0) → count holds 5 for 10 cycles with no irq; start with period=1 → irq 2 edges later.
- start and stop asserted on the same cycle → treated as start: running=1, count=period.
- Assert rst asynchronously mid-count, with irq=1 and overrun=1 → all outputs 0 immediately; no irq afterwards until a new start.
